universal_register: RTL and testbench

//   Parametrised successor to the single-bit D flip-flop with synchronous enable.
//   It is a WIDTH-bit register with one clock enable and a 3-bit mode select:

---
 rtl/universal_register.sv | 59 +++++
 tb/tb_universal_register.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/universal_register.sv
// WIDTH-bit general-purpose storage element: hold, load, shift, rotate, increment
// and clear under a single clock enable, with serial chain taps and a zero flag.
module universal_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;

  // Increment with the wrap carry in the top bit.
  function automatic logic [WIDTH:0] inc_wrap(input logic [WIDTH-1:0] v);
    return {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= RESET_VAL;
      co <= 1'b0;
    end else if (en) begin
      // Every enabled mode clears co; only INC overrides it below.
      co <= 1'b0;
      case (mode)
        MODE_HOLD: q <= q;
        MODE_LOAD: q <= d;
        MODE_SHL:  q <= {q[WIDTH-2:0], sin_lsb};
        MODE_SHR:  q <= {sin_msb, q[WIDTH-1:1]};
        MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
        MODE_INC:  {co, q} <= inc_wrap(q);
        default:   q <= '0;
      endcase
    end
  end

  // Serial taps come from the pre-edge q so chained instances shift coherently.
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign zero     = (q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: two chained 8-bit instances checked every cycle
// against a 16-bit arithmetic model, plus directed literal checks.
module tb_universal_register;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d_lo = 8'h00;
  logic [7:0] d_hi = 8'h00;
  logic       sin_l = 1'b0;
  logic       sin_m = 1'b0;

  logic [7:0] q_lo, q_hi;
  logic       co_lo, co_hi, smsb_lo, smsb_hi, slsb_lo, slsb_hi, zero_lo, zero_hi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  universal_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_lo (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d_lo),
    .sin_lsb(sin_l), .sin_msb(slsb_hi),
    .q(q_lo), .co(co_lo), .sout_msb(smsb_lo), .sout_lsb(slsb_lo), .zero(zero_lo)
  );

  universal_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_hi (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d_hi),
    .sin_lsb(smsb_lo), .sin_msb(sin_m),
    .q(q_hi), .co(co_hi), .sout_msb(smsb_hi), .sout_lsb(slsb_hi), .zero(zero_hi)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dl, input logic [7:0] dh,
                      input logic sl, input logic sm);
    reset = r; en = e; mode = m; d_lo = dl; d_hi = dh; sin_l = sl; sin_m = sm;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] b);
    return 8'((b << 1) | (b >> 7));
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] b);
    return 8'((b >> 1) | (b << 7));
  endfunction

  // Reference: the pair is one 16-bit word for shifts, two bytes otherwise.
  logic [7:0] m_lo = 8'h00, m_hi = 8'h00;
  logic       mco_lo = 1'b0, mco_hi = 1'b0, mvalid = 1'b0;

  always @(posedge clk) begin
    logic [15:0] w;
    logic        cl, ch;
    w = {m_hi, m_lo}; cl = mco_lo; ch = mco_hi;
    if (reset) begin
      w = 16'hA5A5; cl = 1'b0; ch = 1'b0;
    end else if (en) begin
      cl = 1'b0; ch = 1'b0;
      case (mode)
        3'd1: w = {d_hi, d_lo};
        3'd2: w = 16'((w << 1) | {15'd0, sin_l});
        3'd3: w = 16'((w >> 1) | {sin_m, 15'd0});
        3'd4: w = {rotl8(w[15:8]), rotl8(w[7:0])};
        3'd5: w = {rotr8(w[15:8]), rotr8(w[7:0])};
        3'd6: begin
          cl = (w[7:0] == 8'hFF);
          ch = (w[15:8] == 8'hFF);
          w = {8'(w[15:8] + 8'd1), 8'(w[7:0] + 8'd1)};
        end
        3'd7: w = 16'd0;
        default: ;
      endcase
    end
    m_lo   <= w[7:0];
    m_hi   <= w[15:8];
    mco_lo <= cl;
    mco_hi <= ch;
    mvalid <= mvalid | reset;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_lo", {4'd0, q_lo, co_lo, zero_lo, smsb_lo, slsb_lo},
                      {4'd0, m_lo, mco_lo, (m_lo == 8'd0), m_lo[7], m_lo[0]});
      chk("model_hi", {4'd0, q_hi, co_hi, zero_hi, smsb_hi, slsb_hi},
                      {4'd0, m_hi, mco_hi, (m_hi == 8'd0), m_hi[7], m_hi[0]});
    end
  end

  initial begin
    // 1. reset priority, enable low
    step(1, 1, 3'd1, 8'h3C, 8'h3C, 0, 0);
    chk("rst_q", 16'(q_lo), 16'h00A5);
    chk("rst_co", 16'(co_lo), 16'h0000);
    chk("rst_zero", 16'(zero_lo), 16'h0000);
    step(0, 0, 3'd1, 8'h3C, 8'h3C, 0, 0);
    chk("en0_hold", 16'(q_lo), 16'h00A5);

    // 2. load and shifts (upper holds 0 so the chain matches lone-register values)
    step(0, 1, 3'd1, 8'h81, 8'h00, 0, 0);
    step(0, 1, 3'd2, 8'h00, 8'h00, 1, 0);
    chk("shl", 16'(q_lo), 16'h0003);
    chk("shl_hi", 16'(q_hi), 16'h0001);
    step(0, 1, 3'd3, 8'h00, 8'h00, 0, 1);
    chk("shr1", 16'(q_lo), 16'h0081);
    chk("sout_lsb_pre", 16'(slsb_lo), 16'h0001);
    step(0, 1, 3'd3, 8'h00, 8'h00, 0, 0);
    chk("shr0", 16'(q_lo), 16'h0040);

    // 3. rotates
    step(0, 1, 3'd1, 8'h81, 8'h00, 0, 0);
    step(0, 1, 3'd4, 8'h00, 8'h00, 0, 0);
    chk("rol", 16'(q_lo), 16'h0003);
    step(0, 1, 3'd5, 8'h00, 8'h00, 0, 0);
    chk("ror1", 16'(q_lo), 16'h0081);
    step(0, 1, 3'd5, 8'h00, 8'h00, 0, 0);
    chk("ror2", 16'(q_lo), 16'h00C0);
    step(0, 1, 3'd1, 8'h5A, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd4, 8'h00, 8'h00, 0, 0);
    chk("rol8", 16'(q_lo), 16'h005A);

    // 4. increment wrap and carry hold
    step(0, 1, 3'd1, 8'hFE, 8'h00, 0, 0);
    step(0, 1, 3'd6, 8'h00, 8'h00, 0, 0);
    chk("inc_q", 16'(q_lo), 16'h00FF);
    chk("inc_co", 16'(co_lo), 16'h0000);
    step(0, 1, 3'd6, 8'h00, 8'h00, 0, 0);
    chk("wrap_q", 16'(q_lo), 16'h0000);
    chk("wrap_co", 16'(co_lo), 16'h0001);
    chk("wrap_zero", 16'(zero_lo), 16'h0001);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd7, 8'h11, 8'h11, 1, 1);
    chk("co_hold", 16'(co_lo), 16'h0001);
    step(0, 1, 3'd0, 8'h00, 8'h00, 0, 0);
    chk("hold_clr_co", 16'(co_lo), 16'h0000);

    // 5. clear vs reset, reset mid-burst
    step(0, 1, 3'd1, 8'h77, 8'h00, 0, 0);
    step(0, 1, 3'd7, 8'h00, 8'h00, 0, 0);
    chk("clr_q", 16'(q_lo), 16'h0000);
    chk("clr_zero", 16'(zero_lo), 16'h0001);
    step(0, 1, 3'd1, 8'h01, 8'h00, 0, 0);
    step(0, 1, 3'd2, 8'h00, 8'h00, 0, 0);
    step(0, 1, 3'd2, 8'h00, 8'h00, 0, 0);
    chk("burst2", 16'(q_lo), 16'h0004);
    step(1, 1, 3'd2, 8'h00, 8'h00, 0, 0);
    chk("burst_rst", 16'(q_lo), 16'h00A5);
    step(0, 1, 3'd2, 8'h00, 8'h00, 0, 0);
    step(0, 1, 3'd2, 8'h00, 8'h00, 0, 0);
    chk("burst_resume", {q_hi, q_lo}, 16'h9694);

    // 6. chaining
    step(0, 1, 3'd1, 8'h80, 8'h00, 0, 0);
    step(0, 1, 3'd2, 8'h00, 8'h00, 0, 0);
    chk("chain_hi", 16'(q_hi), 16'h0001);
    chk("chain_lo", 16'(q_lo), 16'h0000);

    // random ops against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
